// File: rtl/video_cvbs_enc.sv
// video_cvbs_enc: composite video encoder for a 263-line, 59.94 FPS system.
// Internal H/V/frame timing, a phase-accumulator subcarrier and a 3-stage pipeline to the DAC.
module video_cvbs_enc #(
  parameter int C_V_W       = 6,
  parameter int C_Y_W       = 6,
  parameter int C_PH_W      = 3,
  parameter int C_CA_W      = 3,
  parameter int C_LUT_W     = 6,
  parameter int C_ACC_W     = 16,
  parameter int C_PH_INC    = 19115,
  parameter int C_PEDE      = 12,
  parameter int C_BURST_AMP = 3,
  parameter int C_H_TOTAL   = 780,
  parameter int C_H_SYNC    = 58,
  parameter int C_BURST_ST  = 64,
  parameter int C_BURST_N   = 31,
  parameter int C_H_ACT_ST  = 128,
  parameter int C_H_ACT     = 640,
  parameter int C_V_TOTAL   = 263,
  parameter int C_V_ACT     = 240,
  parameter int C_V_SYNC_ST = 245,
  parameter int C_V_SYNC_N  = 3
) (
  input  logic               CK_i,
  input  logic               XARST_i,
  input  logic               CK_EE_i,
  input  logic [C_Y_W-1:0]   YYs_i,
  input  logic [C_PH_W-1:0]  CPHs_i,
  input  logic [C_CA_W-1:0]  CAMPs_i,
  input  logic               COLOR_EN_i,
  output logic               XBLK_o,
  output logic [9:0]         HCTRs_o,
  output logic [8:0]         VCTRs_o,
  output logic [7:0]         FCTRs_o,
  output logic               HVcy_o,
  output logic [C_V_W-1:0]   VIDEOs_o
);
  localparam int SW  = C_V_W + 2;
  localparam int PW  = C_LUT_W + C_CA_W + 1;
  localparam int NPH = 2 ** C_PH_W;

  localparam logic [9:0] H_LAST  = 10'(C_H_TOTAL - 1);
  localparam logic [9:0] H_SYNC  = 10'(C_H_SYNC);
  localparam logic [9:0] H_VSYNC = 10'(C_H_TOTAL - C_H_SYNC);
  localparam logic [9:0] B_ST    = 10'(C_BURST_ST);
  localparam logic [9:0] B_END   = 10'(C_BURST_ST + C_BURST_N);
  localparam logic [9:0] A_ST    = 10'(C_H_ACT_ST);
  localparam logic [9:0] A_END   = 10'(C_H_ACT_ST + C_H_ACT);
  localparam logic [8:0] V_LAST  = 9'(C_V_TOTAL - 1);
  localparam logic [8:0] V_ACT   = 9'(C_V_ACT);
  localparam logic [8:0] V_ALAST = 9'(C_V_ACT - 1);
  localparam logic [8:0] VS_ST   = 9'(C_V_SYNC_ST);
  localparam logic [8:0] VS_END  = 9'(C_V_SYNC_ST + C_V_SYNC_N);

  localparam logic [C_ACC_W-1:0]     ACC_INC = C_ACC_W'(C_PH_INC);
  localparam logic [C_PH_W-1:0]      PH_HALF = C_PH_W'(1 << (C_PH_W - 1));
  localparam logic signed [C_CA_W:0] BURST_M = (C_CA_W + 1)'(C_BURST_AMP);
  localparam logic signed [PW-1:0]   RND     = PW'((1 << (C_LUT_W - 1)) - 1);
  localparam logic signed [SW-1:0]   PEDE_S  = SW'(C_PEDE);
  localparam logic signed [SW-1:0]   MAXV    = SW'((1 << C_V_W) - 1);
  localparam logic [C_V_W-1:0]       PEDE_V  = C_V_W'(C_PEDE);

  // Sine table, rounded to nearest, built at elaboration.
  logic signed [C_LUT_W-1:0] lut [NPH];
  for (genvar gi = 0; gi < NPH; gi++) begin : g_lut
    localparam real ANG = 2.0 * 3.14159265358979 * gi / (2.0 ** C_PH_W);
    localparam real VAL = ((2.0 ** (C_LUT_W - 1)) - 1.0) * $sin(ANG);
    localparam int  IV  = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
    assign lut[gi] = C_LUT_W'(IV);
  end

  logic [9:0]         h_q, h_d;
  logic [8:0]         v_q, v_d;
  logic [7:0]         f_q, f_d;
  logic [C_ACC_W-1:0] acc_q, acc_d;

  logic              vs_line, sync_c, burst_c, act_c;
  logic [C_PH_W-1:0] acc_top;

  logic              s1_sync_q, s1_burst_q, s1_act_q;
  logic [C_Y_W-1:0]  s1_y_q, s1_y_d;
  logic [C_CA_W-1:0] s1_ca_q, s1_ca_d;
  logic [C_PH_W-1:0] s1_idx_q, s1_idx_d;

  logic              s2_sync_q, s2_burst_q, s2_act_q;
  logic [C_Y_W-1:0]  s2_y_q;
  logic signed [SW-1:0] s2_chroma_q, s2_chroma_d;

  logic [C_V_W-1:0]  vid_q, vid_d;

  logic signed [C_CA_W:0] mult;
  logic signed [PW-1:0]   prod, prod_b, shr;
  logic signed [SW-1:0]   y_ext, sum;
  logic [C_V_W-1:0]       sat;

  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    f_d   = f_q;
    acc_d = acc_q;
    if (CK_EE_i) begin
      acc_d = acc_q + ACC_INC;
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
          f_d = f_q + 8'd1;
        end else begin
          v_d = v_q + 9'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Region decode from the current counters; vsync lines carry an inverted sync pulse.
  always_comb begin
    vs_line = (v_q >= VS_ST) && (v_q < VS_END);
    sync_c  = vs_line ? (h_q < H_VSYNC) : (h_q < H_SYNC);
    burst_c = !vs_line && (h_q >= B_ST) && (h_q < B_END) && COLOR_EN_i;
    act_c   = (v_q < V_ACT) && (h_q >= A_ST) && (h_q < A_END);
    acc_top = acc_q[C_ACC_W-1 -: C_PH_W];
    s1_y_d   = act_c ? YYs_i : s1_y_q;
    s1_ca_d  = act_c ? (COLOR_EN_i ? CAMPs_i : '0) : s1_ca_q;
    s1_idx_d = burst_c ? (acc_top + PH_HALF) : (act_c ? (acc_top + CPHs_i) : s1_idx_q);
  end

  // Chroma scaling, shifted with truncation toward zero so +/- peaks stay symmetric.
  always_comb begin
    mult        = s1_burst_q ? BURST_M : signed'({1'b0, s1_ca_q});
    prod        = PW'(lut[s1_idx_q]) * PW'(mult);
    prod_b      = prod[PW-1] ? (prod + RND) : prod;
    shr         = prod_b >>> (C_LUT_W - 1);
    s2_chroma_d = SW'(shr);
  end

  always_comb begin
    y_ext = s2_burst_q ? '0 : signed'(SW'(s2_y_q));
    sum   = PEDE_S + y_ext + s2_chroma_q;
    if (sum[SW-1])      sat = '0;
    else if (sum > MAXV) sat = '1;
    else                sat = sum[C_V_W-1:0];
    if (s2_sync_q)       vid_d = '0;
    else if (s2_burst_q) vid_d = sat;
    else if (!s2_act_q)  vid_d = PEDE_V;
    else                 vid_d = sat;
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      h_q         <= '0;
      v_q         <= '0;
      f_q         <= '0;
      acc_q       <= '0;
      s1_sync_q   <= 1'b0;
      s1_burst_q  <= 1'b0;
      s1_act_q    <= 1'b0;
      s1_y_q      <= '0;
      s1_ca_q     <= '0;
      s1_idx_q    <= '0;
      s2_sync_q   <= 1'b0;
      s2_burst_q  <= 1'b0;
      s2_act_q    <= 1'b0;
      s2_y_q      <= '0;
      s2_chroma_q <= '0;
      vid_q       <= PEDE_V;
    end else if (CK_EE_i) begin
      h_q         <= h_d;
      v_q         <= v_d;
      f_q         <= f_d;
      acc_q       <= acc_d;
      s1_sync_q   <= sync_c;
      s1_burst_q  <= burst_c;
      s1_act_q    <= act_c;
      s1_y_q      <= s1_y_d;
      s1_ca_q     <= s1_ca_d;
      s1_idx_q    <= s1_idx_d;
      s2_sync_q   <= s1_sync_q;
      s2_burst_q  <= s1_burst_q;
      s2_act_q    <= s1_act_q;
      s2_y_q      <= s1_y_q;
      s2_chroma_q <= s2_chroma_d;
      vid_q       <= vid_d;
    end
  end

  assign XBLK_o   = act_c;
  assign HCTRs_o  = h_q;
  assign VCTRs_o  = v_q;
  assign FCTRs_o  = f_q;
  assign HVcy_o   = (v_q == V_ALAST) && (h_q == H_LAST) && CK_EE_i;
  assign VIDEOs_o = vid_q;

endmodule
